jtkiwi_tile_draw: RTL and testbench

//  Parametrised tile-row renderer for the SETA tile-map layer. It replaces the fixed 16-pixel, 4bpp drawer.
//  On each draw request it fetches one tile row from graphics ROM and writes palette-tagged pixels into the tile line buffer.
//  New over the previous drawer: 8- or 16-pixel tiles, latched request fields, prefetch of the second ROM word while shifting, and optional pen-0 transparency.

---
 rtl/jtkiwi_tile_draw_pkg.sv | 19 +
 rtl/jtkiwi_tile_shift.sv | 38 +++
 rtl/jtkiwi_tile_draw.sv | 162 ++++++++++++++++
 tb/tb_jtkiwi_tile_draw.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkiwi_tile_draw_pkg.sv
// Shared definitions for the SETA tile-row renderer: pixel format,
// ROM word layout helpers and the drawer state encoding.
package jtkiwi_tile_draw_pkg;

  localparam int BPP      = 4;  // bits per pixel, one per plane
  localparam int WORD_PIX = 8;  // pixels carried by one 32-bit ROM word

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT
  } state_t;

  // Plane k lives in byte k; col selects the pixel column inside each byte.
  function automatic logic [BPP-1:0] pick_pen(input logic [31:0] w, input logic [2:0] col);
    return {w[{2'd3, col}], w[{2'd2, col}], w[{2'd1, col}], w[{2'd0, col}]};
  endfunction

endpackage

// File: rtl/jtkiwi_tile_shift.sv
// 32-bit planar pixel shifter: presents one 4-bit pen per cycle, eight
// pens per loaded word, direction chosen by the horizontal flip.
module jtkiwi_tile_shift
  import jtkiwi_tile_draw_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           hflip,
  input  logic [31:0]    data,
  output logic [BPP-1:0] pen,
  output logic           empty,
  output logic           last
);

  logic [31:0] sreg;
  logic [3:0]  cnt;

  assign empty = (cnt == 4'(WORD_PIX));
  assign last  = (cnt == 4'(WORD_PIX - 1));
  // Flipped rows are read from the top bit of each plane byte downwards.
  assign pen   = pick_pen(sreg, hflip ? 3'd7 : 3'd0);

  // Load a fresh word or advance one pixel while pixels remain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= 4'(WORD_PIX);
    end else if (load) begin
      sreg <= data;
      cnt  <= '0;
    end else if (!empty) begin
      sreg <= hflip ? (sreg << 1) : (sreg >> 1);
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/jtkiwi_tile_draw.sv
// Tile-row renderer: latches a draw request, fetches one or two ROM words
// (the second one prefetched while the first is shifting) and writes
// palette-tagged pixels into the line buffer.
module jtkiwi_tile_draw
  import jtkiwi_tile_draw_pkg::*;
#(
  parameter int  CW     = 13,
  parameter int  PW     = 5,
  parameter int  AW     = 9,
  parameter int  TW     = 16,
  parameter int  TH     = 16,
  parameter int  TRANSP = 0,
  localparam int YW     = $clog2(TH),
  localparam int WB     = TW / 16,
  localparam int RW     = CW + YW + WB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              draw,
  output logic              busy,
  input  logic [CW-1:0]     code,
  input  logic              hflip,
  input  logic              vflip,
  input  logic [PW-1:0]     pal,
  input  logic [AW-1:0]     xpos,
  input  logic [YW-1:0]     ysub,
  output logic [RW-1:0]     rom_addr,
  output logic              rom_cs,
  input  logic              rom_ok,
  input  logic [31:0]       rom_data,
  output logic [AW-1:0]     buf_addr,
  output logic              buf_we,
  output logic [PW+BPP-1:0] buf_din
);

  localparam logic [1:0] NW = 2'(TW / 8);

  state_t          state, state_nx;
  logic [CW-1:0]   code_r;
  logic            hflip_r;
  logic [PW-1:0]   pal_r;
  logic [YW-1:0]   ysubf_r;
  logic            word;
  logic            fetched;
  logic [1:0]      nload;
  logic [31:0]     hold_data;
  logic            hold_vld;
  logic            pixel_vld;
  logic [BPP-1:0]  sh_pen;
  logic            sh_empty, sh_last, sh_load;
  logic [31:0]     sh_data;
  logic            accept_req, accept_word, row_done;

  assign busy        = (state != ST_IDLE) | pixel_vld;
  assign accept_req  = draw & ~busy;
  assign accept_word = rom_cs & rom_ok;
  // A word enters the shifter as soon as the current one is spent; a word
  // arriving on the last shift bypasses the hold register.
  assign sh_load     = (sh_empty | sh_last) & (hold_vld | accept_word);
  assign sh_data     = hold_vld ? hold_data : rom_data;
  assign row_done    = sh_last & ~sh_load & (nload == NW);

  jtkiwi_tile_shift u_shift (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sh_load),
    .hflip (hflip_r),
    .data  (sh_data),
    .pen   (sh_pen),
    .empty (sh_empty),
    .last  (sh_last)
  );

  // Word address {code, ysubf[YW-1:3], word, ysubf[2:0]}; word bit only for 16-pixel tiles.
  always_comb begin
    rom_addr = RW'(code_r) << (YW + WB);
    rom_addr = rom_addr | (RW'(ysubf_r >> 3) << (3 + WB));
    if (WB == 1) rom_addr = rom_addr | (RW'(word) << 3);
    rom_addr = rom_addr | RW'(ysubf_r[2:0]);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next state: wait for request, wait for first word, shift until the row ends.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept_req) state_nx = ST_FETCH;
      ST_FETCH: if (sh_load)    state_nx = ST_SHIFT;
      ST_SHIFT: if (row_done)   state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  // Request latch and ROM request sequencing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_r  <= '0;
      hflip_r <= 1'b0;
      pal_r   <= '0;
      ysubf_r <= '0;
      word    <= 1'b0;
      fetched <= 1'b0;
      rom_cs  <= 1'b0;
      nload   <= '0;
    end else if (accept_req) begin
      code_r  <= code;
      hflip_r <= hflip;
      pal_r   <= pal;
      // ROM rows are stored bottom-up, so an unflipped row index is inverted.
      ysubf_r <= vflip ? ysub : ~ysub;
      word    <= hflip;
      fetched <= 1'b0;
      rom_cs  <= 1'b1;
      nload   <= '0;
    end else begin
      if (accept_word) begin
        if (NW == 2'd1 || fetched) begin
          rom_cs <= 1'b0;
        end else begin
          word    <= ~word;
          fetched <= 1'b1;
        end
      end
      if (sh_load) nload <= nload + 1'b1;
    end
  end

  // Prefetched second word waits here until the shifter frees up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_data <= '0;
      hold_vld  <= 1'b0;
    end else if (accept_word && !sh_load) begin
      hold_data <= rom_data;
      hold_vld  <= 1'b1;
    end else if (sh_load && hold_vld) begin
      hold_vld  <= 1'b0;
    end
  end

  // Registered line-buffer write port; the address advances on every pixel, written or not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_vld <= 1'b0;
      buf_we    <= 1'b0;
      buf_din   <= '0;
      buf_addr  <= '0;
    end else begin
      pixel_vld <= ~sh_empty;
      buf_we    <= ~sh_empty & ~((TRANSP != 0) && (sh_pen == '0));
      buf_din   <= {pal_r, sh_pen};
      if (accept_req)     buf_addr <= xpos;
      else if (pixel_vld) buf_addr <= buf_addr + 1'b1;
    end
  end

endmodule

// File: tb/tb_jtkiwi_tile_draw.sv
// Scoreboard bench for jtkiwi_tile_draw: two instances (opaque and pen-0
// transparent) share stimulus and ROM; a reference model predicts ROM
// fetches and line-buffer writes, a monitor checks them as they appear.
module tb_jtkiwi_tile_draw;

  localparam int CW = 13, PW = 5, AW = 9, YW = 4, RW = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          draw = 1'b0;
  logic [CW-1:0] code = '0;
  logic          hflip = 1'b0, vflip = 1'b0;
  logic [PW-1:0] pal = '0;
  logic [AW-1:0] xpos = '0;
  logic [YW-1:0] ysub = '0;
  logic          rom_ok = 1'b0;
  logic [31:0]   rom_data = '0;

  logic          busy0, busy1, rom_cs0, rom_cs1, buf_we0, buf_we1;
  logic [RW-1:0] rom_addr0, rom_addr1;
  logic [AW-1:0] buf_addr0, buf_addr1;
  logic [8:0]    buf_din0, buf_din1;

  jtkiwi_tile_draw #(.TRANSP(0)) u0 (
    .clk(clk), .rst_n(rst_n), .draw(draw), .busy(busy0), .code(code),
    .hflip(hflip), .vflip(vflip), .pal(pal), .xpos(xpos), .ysub(ysub),
    .rom_addr(rom_addr0), .rom_cs(rom_cs0), .rom_ok(rom_ok), .rom_data(rom_data),
    .buf_addr(buf_addr0), .buf_we(buf_we0), .buf_din(buf_din0)
  );

  jtkiwi_tile_draw #(.TRANSP(1)) u1 (
    .clk(clk), .rst_n(rst_n), .draw(draw), .busy(busy1), .code(code),
    .hflip(hflip), .vflip(vflip), .pal(pal), .xpos(xpos), .ysub(ysub),
    .rom_addr(rom_addr1), .rom_cs(rom_cs1), .rom_ok(rom_ok), .rom_data(rom_data),
    .buf_addr(buf_addr1), .buf_we(buf_we1), .buf_din(buf_din1)
  );

  int compared = 0;
  int mismatched = 0;

  logic [31:0]   rom [int];
  logic [17:0]   q0[$], q1[$];
  logic [RW-1:0] qa0[$], qa1[$];
  int            ok_mode = 0;
  int            stall_left = 0;
  logic          first_bit = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] rd(input logic [RW-1:0] a);
    if (rom.exists(int'(a))) return rom[int'(a)];
    return 32'h0;
  endfunction

  // Word address from the request fields; rows are stored bottom-up in ROM.
  function automatic logic [RW-1:0] addr_of(input logic [CW-1:0] c, input logic vf,
                                            input logic [YW-1:0] y, input logic w);
    logic [YW-1:0] yf;
    yf = vf ? y : ~y;
    return {c, yf[3], w, yf[2:0]};
  endfunction

  // Reference: build the 16-pixel row left to right, then read it in display order.
  task automatic model(input logic [CW-1:0] c, input logic hf, input logic vf,
                       input logic [PW-1:0] p, input logic [AW-1:0] x, input logic [YW-1:0] y);
    logic [3:0]  row [16];
    logic [31:0] d;
    logic [3:0]  pen;
    logic [AW-1:0] a;
    for (int i = 0; i < 16; i++) begin
      d = rd(addr_of(c, vf, y, (i >= 8)));
      row[i] = {d[24 + i % 8], d[16 + i % 8], d[8 + i % 8], d[i % 8]};
    end
    qa0.push_back(addr_of(c, vf, y, hf));
    qa0.push_back(addr_of(c, vf, y, !hf));
    qa1.push_back(addr_of(c, vf, y, hf));
    qa1.push_back(addr_of(c, vf, y, !hf));
    for (int j = 0; j < 16; j++) begin
      pen = row[hf ? 15 - j : j];
      a = AW'((int'(x) + j) % 512);
      q0.push_back({a, p, pen});
      if (pen != 4'h0) q1.push_back({a, p, pen});
    end
  endtask

  // ROM model: data follows the presented address; rom_ok pattern by mode.
  always @(posedge clk) begin
    #1;
    rom_data = rd(rom_addr0);
    case (ok_mode)
      0: rom_ok = 1'b1;
      1: rom_ok = ($urandom_range(0, 3) != 0);
      default: begin
        if (rom_cs0 && rom_addr0[3] != first_bit && stall_left > 0) begin
          rom_ok = 1'b0;
          stall_left--;
        end else begin
          rom_ok = 1'b1;
        end
      end
    endcase
  end

  // Monitor: every accepted fetch and every buffer write pops one expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rom_cs0 && rom_ok) begin
        if (qa0.size() == 0) fail_now("rom_fetch0 unexpected");
        else chk("rom_addr0", 32'(rom_addr0), 32'(qa0.pop_front()));
      end
      if (rom_cs1 && rom_ok) begin
        if (qa1.size() == 0) fail_now("rom_fetch1 unexpected");
        else chk("rom_addr1", 32'(rom_addr1), 32'(qa1.pop_front()));
      end
      if (buf_we0) begin
        if (q0.size() == 0) fail_now("write0 unexpected");
        else chk("write0 {addr,din}", 32'({buf_addr0, buf_din0}), 32'(q0.pop_front()));
      end
      if (buf_we1) begin
        if (q1.size() == 0) fail_now("write1 unexpected");
        else chk("write1 {addr,din}", 32'({buf_addr1, buf_din1}), 32'(q1.pop_front()));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((busy0 || busy1) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) fail_now("wait_idle timeout");
  endtask

  // Issue one row; returns one time unit after the sampling edge.
  task automatic start_row(input logic [CW-1:0] c, input logic hf, input logic vf,
                           input logic [PW-1:0] p, input logic [AW-1:0] x,
                           input logic [YW-1:0] y, input logic [31:0] d0, input logic [31:0] d1);
    wait_idle();
    rom[int'(addr_of(c, vf, y, 1'b0))] = d0;
    rom[int'(addr_of(c, vf, y, 1'b1))] = d1;
    model(c, hf, vf, p, x, y);
    first_bit = hf;
    code = c; hflip = hf; vflip = vf; pal = p; xpos = x; ysub = y;
    draw = 1'b1;
    @(posedge clk); #1;
    draw = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, m;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy0, 0);
    chk("reset_rom_cs", rom_cs0, 0);
    chk("reset_buf_we", buf_we0, 0);
    chk("reset_buf_addr", buf_addr0, 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic row with latency and busy length.
    ok_mode = 0;
    start_row(13'h0123, 1'b0, 1'b0, 5'h15, 9'd20, 4'd2, 32'h0F0F0F0F, 32'h0);
    chk("accept_busy_cs", {busy0, rom_cs0}, 2'b11);
    chk("basic_rom_addr", rom_addr0, {13'h0123, 1'b1, 1'b0, 3'd5});
    n = 0;
    while (!buf_we0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("first_we_edges", n, 2);
    m = 0;
    while (busy0 && m < 200) begin @(posedge clk); #1; m++; end
    chk("busy_pixel_cycles", m, 16);

    // Horizontal flip: second half fetched first, pixels reversed.
    start_row(13'h0123, 1'b1, 1'b0, 5'h0A, 9'd64, 4'd2, 32'h0F0F0F0F, 32'h0);
    chk("hflip_first_word", rom_addr0[3], 1);
    start_row(13'h1ABC, 1'b0, 1'b1, 5'h03, 9'd200, 4'd9, 32'h12345678, 32'h9ABCDEF0);

    // Transparency: only the first pixel of the transparent instance is written.
    start_row(13'h0042, 1'b0, 1'b0, 5'h1F, 9'd100, 4'd0, 32'h00000001, 32'h0);
    wait_idle();
    chk("transp_end_addr", buf_addr1, 116);
    chk("opaque_end_addr", buf_addr0, 116);

    // Wrap around with a draw pulsed while busy.
    start_row(13'h0777, 1'b0, 1'b0, 5'h11, 9'd510, 4'd5, 32'hA5A5A5A5, 32'h3C3C3C3C);
    repeat (4) @(posedge clk);
    #1;
    code = 13'h1FFF; xpos = 9'd300; pal = 5'h01;
    draw = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    draw = 1'b0;
    wait_idle();
    chk("wrap_end_addr", buf_addr0, 14);

    // Stall on the second word.
    ok_mode = 2;
    stall_left = 12;
    start_row(13'h0321, 1'b0, 1'b0, 5'h07, 9'd40, 4'd7, 32'hFFFF0000, 32'h00FF00FF);
    repeat (11) @(posedge clk);
    #1;
    chk("stall_buf_we", buf_we0, 0);
    chk("stall_buf_addr", buf_addr0, 48);
    chk("stall_busy", busy0, 1);
    wait_idle();
    ok_mode = 0;

    // Reset mid-row.
    start_row(13'h0555, 1'b1, 1'b1, 5'h09, 9'd0, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_busy", busy0, 0);
    chk("midreset_rom_cs", rom_cs0, 0);
    chk("midreset_buf_we", {buf_we0, buf_we1}, 0);
    q0.delete(); q1.delete(); qa0.delete(); qa1.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_reset_quiet", {busy0, buf_we0}, 0);

    // Randomized rows with random ROM latency and stray draws while busy.
    ok_mode = 1;
    for (int r = 0; r < 40; r++) begin
      start_row(CW'($urandom), 1'($urandom), 1'($urandom), PW'($urandom), AW'($urandom),
                YW'($urandom), $urandom & $urandom, $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1;
        if (busy0) begin
          code = CW'($urandom); xpos = AW'($urandom); pal = PW'($urandom);
          draw = 1'b1;
          @(posedge clk); #1;
          draw = 1'b0;
        end
      end
    end
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("queues_drained", q0.size() + q1.size() + qa0.size() + qa1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
